// File: rtl/calc_sequencer.sv
// Keypad sequencer for the four-digit BCD adder: converts key strobes into
// push/guardar/finalizar/clr pulses and enforces A, +, B, = entry order.
module calc_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int MAX_DIG = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       ent,
    output logic       push,
    output logic [3:0] entrada,
    output logic       guardar,
    output logic       finalizar,
    output logic       clr,
    output logic       done,
    output logic       err,
    output logic       ignored,
    output logic [2:0] state,
    output logic [2:0] dig_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        WAIT_RES = 3'd2,
        SHOW     = 3'd3,
        RELOAD   = 3'd4,
        ERROR    = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      dig_cnt_q, dig_cnt_d;
    logic [3:0]      entrada_q, entrada_d;
    logic [3:0]      dig_buf_q, dig_buf_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            push_q, push_d;
    logic            guardar_q, guardar_d;
    logic            finalizar_q, finalizar_d;
    logic            clr_q, clr_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
    logic            ignored_q, ignored_d;

    logic            key_clr, key_dig, key_add, key_eq;

    always_comb begin
        state_d     = state_q;
        dig_cnt_d   = dig_cnt_q;
        entrada_d   = entrada_q;
        dig_buf_d   = dig_buf_q;
        tmr_d       = tmr_q;
        push_d      = 1'b0;
        guardar_d   = 1'b0;
        finalizar_d = 1'b0;
        clr_d       = 1'b0;
        ignored_d   = 1'b0;

        key_clr = key_valid && (key_code == 4'hC);
        key_dig = key_valid && (key_code <= 4'd9);
        key_add = key_valid && (key_code == 4'hA);
        key_eq  = key_valid && (key_code == 4'hB);

        if (key_clr) begin
            clr_d     = 1'b1;
            state_d   = ENTER_A;
            dig_cnt_d = 3'd0;
        end else begin
            case (state_q)
                ENTER_A, ENTER_B: begin
                    if (key_dig && (dig_cnt_q < 3'(MAX_DIG))) begin
                        push_d    = 1'b1;
                        entrada_d = key_code;
                        dig_cnt_d = dig_cnt_q + 3'd1;
                    end else if (key_add && (state_q == ENTER_A) && (dig_cnt_q != 3'd0)) begin
                        guardar_d = 1'b1;
                        state_d   = ENTER_B;
                        dig_cnt_d = 3'd0;
                    end else if (key_eq && (state_q == ENTER_B) && (dig_cnt_q != 3'd0)) begin
                        finalizar_d = 1'b1;
                        state_d     = WAIT_RES;
                        tmr_d       = TW'(TIMEOUT);
                    end else if (key_valid) begin
                        ignored_d = 1'b1;
                    end
                end
                WAIT_RES: begin
                    ignored_d = key_valid;
                    // ent coinciding with the finalizar cycle belongs to a stale result
                    if (ent && !finalizar_q) begin
                        state_d = SHOW;
                    end else if (tmr_q == '0) begin
                        state_d = ERROR;
                    end else begin
                        tmr_d = tmr_q - TW'(1);
                    end
                end
                SHOW: begin
                    if (key_dig) begin
                        clr_d     = 1'b1;
                        dig_buf_d = key_code;
                        state_d   = RELOAD;
                    end else begin
                        ignored_d = key_valid;
                    end
                end
                RELOAD: begin
                    push_d    = 1'b1;
                    entrada_d = dig_buf_q;
                    dig_cnt_d = 3'd1;
                    state_d   = ENTER_A;
                    ignored_d = key_valid;
                end
                ERROR: begin
                    ignored_d = key_valid;
                end
                default: begin
                    state_d = ENTER_A;
                end
            endcase
        end

        done_d = (state_d == SHOW);
        err_d  = (state_d == ERROR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ENTER_A;
            dig_cnt_q   <= 3'd0;
            entrada_q   <= 4'd0;
            dig_buf_q   <= 4'd0;
            tmr_q       <= '0;
            push_q      <= 1'b0;
            guardar_q   <= 1'b0;
            finalizar_q <= 1'b0;
            clr_q       <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ignored_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dig_cnt_q   <= dig_cnt_d;
            entrada_q   <= entrada_d;
            dig_buf_q   <= dig_buf_d;
            tmr_q       <= tmr_d;
            push_q      <= push_d;
            guardar_q   <= guardar_d;
            finalizar_q <= finalizar_d;
            clr_q       <= clr_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ignored_q   <= ignored_d;
        end
    end

    assign push      = push_q;
    assign entrada   = entrada_q;
    assign guardar   = guardar_q;
    assign finalizar = finalizar_q;
    assign clr       = clr_q;
    assign done      = done_q;
    assign err       = err_q;
    assign ignored   = ignored_q;
    assign state     = state_q;
    assign dig_cnt   = dig_cnt_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: behavioural model compared every cycle plus
// hand-computed expectations along the directed key sequences.
module tb_calc_sequencer;

    localparam int TIMEOUT = 16;
    localparam int MAX_DIG = 4;

    localparam int S_A = 0, S_B = 1, S_W = 2, S_SHOW = 3, S_RL = 4, S_ERR = 5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'd0;
    logic       ent = 1'b0;
    logic       push, guardar, finalizar, clr, done, err, ignored;
    logic [3:0] entrada;
    logic [2:0] state, dig_cnt;

    int checks = 0;
    int failures = 0;
    int cycle = 0;

    calc_sequencer #(.TIMEOUT(TIMEOUT), .MAX_DIG(MAX_DIG)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .ent       (ent),
        .push      (push),
        .entrada   (entrada),
        .guardar   (guardar),
        .finalizar (finalizar),
        .clr       (clr),
        .done      (done),
        .err       (err),
        .ignored   (ignored),
        .state     (state),
        .dig_cnt   (dig_cnt)
    );

    always #5 clk = ~clk;

    // Model: current mode, digits typed, last digit sent, pending reload
    // digit, and how many WAIT cycles have elapsed since the sum started.
    int m_state = S_A, m_cnt = 0, m_entrada = 0, m_pending = 0, m_waited = 0;
    bit m_push = 0, m_guardar = 0, m_fin = 0, m_clr = 0, m_ign = 0;

    task automatic model_reset();
        m_state = S_A; m_cnt = 0; m_entrada = 0; m_pending = 0; m_waited = 0;
        m_push = 0; m_guardar = 0; m_fin = 0; m_clr = 0; m_ign = 0;
    endtask

    task automatic model_step(input bit kv, input int kc, input bit e);
        bit is_clear;
        bit is_key;
        is_clear = kv && (kc == 12);
        is_key   = kv && !is_clear;
        m_push = 0; m_guardar = 0; m_fin = 0; m_clr = 0; m_ign = 0;
        if (is_clear) begin
            m_clr = 1; m_state = S_A; m_cnt = 0;
        end else if (m_state == S_A || m_state == S_B) begin
            if (is_key) begin
                if (kc <= 9 && m_cnt < MAX_DIG) begin
                    m_push = 1; m_entrada = kc; m_cnt = m_cnt + 1;
                end else if (kc == 10 && m_state == S_A && m_cnt > 0) begin
                    m_guardar = 1; m_state = S_B; m_cnt = 0;
                end else if (kc == 11 && m_state == S_B && m_cnt > 0) begin
                    m_fin = 1; m_state = S_W; m_waited = 0;
                end else begin
                    m_ign = 1;
                end
            end
        end else if (m_state == S_W) begin
            m_ign = is_key;
            if (m_waited > 0 && e) m_state = S_SHOW;
            else if (m_waited == TIMEOUT) m_state = S_ERR;
            else m_waited = m_waited + 1;
        end else if (m_state == S_SHOW) begin
            if (is_key && kc <= 9) begin
                m_clr = 1; m_pending = kc; m_state = S_RL;
            end else begin
                m_ign = is_key;
            end
        end else if (m_state == S_RL) begin
            m_push = 1; m_entrada = m_pending; m_cnt = 1; m_state = S_A;
            m_ign = is_key;
        end else begin
            m_ign = is_key;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst);
        if (!rst) model_reset();
        else model_step(key_valid, int'(key_code), ent);
    end

    function automatic logic [16:0] pack_dut();
        return {push, entrada, guardar, finalizar, clr, done, err, ignored, state, dig_cnt};
    endfunction

    function automatic logic [16:0] pack_model();
        return {m_push, 4'(m_entrada), m_guardar, m_fin, m_clr,
                (m_state == S_SHOW), (m_state == S_ERR), m_ign, 3'(m_state), 3'(m_cnt)};
    endfunction

    initial forever begin
        @(negedge clk);
        cycle++;
        checks++;
        if (pack_dut() !== pack_model()) begin
            failures++;
            $display("FAIL model_cmp cycle=%0d got={push,entrada,guardar,fin,clr,done,err,ign,state,cnt}=%h expected=%h",
                     cycle, pack_dut(), pack_model());
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'(pack_dut()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(2);
        check_all_zero("reset_outputs");
        rst = 1'b1;
        idle(1);
        check_all_zero("no_pulse_on_release");

        // Plan 1: 1, 2, +, 3, = then ent three cycles after finalizar
        key(4'd1);
        check("t1_push1", push, 1); check("t1_entrada1", entrada, 1);
        key(4'd2);
        check("t1_entrada2", entrada, 2); check("t1_cnt2", dig_cnt, 2);
        key(4'hA);
        check("t1_guardar", guardar, 1); check("t1_state_b", state, 1); check("t1_cnt0", dig_cnt, 0);
        key(4'd3);
        check("t1_entrada3", entrada, 3);
        key(4'hB);
        check("t1_finalizar", finalizar, 1); check("t1_state_w", state, 2);
        idle(3);
        check("t1_still_wait", state, 2);
        ent = 1'b1;
        idle(1);
        ent = 1'b0;
        check("t1_state_show", state, 3); check("t1_done", done, 1);

        // Plan 5: SHOW digit -> clr, then reload push; back-to-back key during RELOAD
        key_valid = 1'b1; key_code = 4'd7;
        idle(1);
        check("t5_clr", clr, 1); check("t5_state_reload", state, 4); check("t5_no_push", push, 0);
        key_code = 4'd8;
        idle(1);
        key_valid = 1'b0;
        check("t5_push", push, 1); check("t5_entrada7", entrada, 7);
        check("t5_cnt1", dig_cnt, 1); check("t5_state_a", state, 0); check("t5_ignored", ignored, 1);

        // Plan 2: digit overflow
        key(4'hC);
        check("t2_clr", clr, 1); check("t2_cnt0", dig_cnt, 0);
        key(4'd5); key(4'd6); key(4'd7); key(4'd8);
        check("t2_cnt4", dig_cnt, 4);
        key(4'd9);
        check("t2_ignored", ignored, 1); check("t2_no_push", push, 0);
        check("t2_cnt_hold", dig_cnt, 4); check("t2_entrada8", entrada, 8);

        // Plan 3: operators with empty operands
        key(4'hC);
        key(4'hA);
        check("t3_plus_ign", ignored, 1); check("t3_no_guardar", guardar, 0); check("t3_state_a", state, 0);
        key(4'd1); key(4'hA);
        key(4'hB);
        check("t3_eq_ign", ignored, 1); check("t3_no_fin", finalizar, 0); check("t3_state_b", state, 1);
        key(4'hE);
        check("t3_unused_ign", ignored, 1);

        // Plan 4: timeout into ERROR
        key(4'd2); key(4'hB);
        check("t4_fin", finalizar, 1);
        idle(16);
        check("t4_err_low_f16", err, 0); check("t4_wait_f16", state, 2);
        idle(1);
        check("t4_err_f17", err, 1); check("t4_state_err", state, 5);
        key(4'd4);
        check("t4_dig_ign", ignored, 1); check("t4_still_err", state, 5);
        key(4'hA);
        check("t4_plus_ign", ignored, 1);
        key(4'hC);
        check("t4_clr", clr, 1); check("t4_state_a", state, 0); check("t4_err_drop", err, 0);

        // Plan 6a: clear beats ent in the same WAIT cycle
        key(4'd1); key(4'hA); key(4'd2); key(4'hB);
        idle(1);
        key_valid = 1'b1; key_code = 4'hC; ent = 1'b1;
        idle(1);
        key_valid = 1'b0; ent = 1'b0;
        check("t6_clr", clr, 1); check("t6_state_a", state, 0); check("t6_done0", done, 0);

        // Plan 6b: asynchronous reset mid-WAIT
        key(4'd1); key(4'hA); key(4'd2); key(4'hB);
        idle(2);
        check("t6_in_wait", state, 2);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_all_zero("t6_async_reset");
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        check_all_zero("t6_release_quiet");
        key(4'd3);
        check("t6_push_after", push, 1); check("t6_cnt_after", dig_cnt, 1);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
